instr_fetch_id: RTL and testbench



---
 rtl/instr_fetch_id.sv | 81 ++++++++
 tb/tb_instr_fetch_id.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_id.sv
// IM/ID pipeline register: captures the fetched instruction, squashes wrong-path
// fetches on a redirect, freezes fetch after HLT and counts squashed fetches.
module instr_fetch_id #(
    parameter int                 INSTR_W   = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter logic [3:0]         HLT_OP    = 4'hF,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr_IM,
    input  logic               stall_IM_ID,
    input  logic               flow_change_ID_EX,
    output logic [INSTR_W-1:0] instr_IM_ID,
    output logic               valid_IM_ID,
    output logic               halt_fetch,
    output logic [CNT_W-1:0]   squash_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t             state_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic [CNT_W-1:0]   squash_cnt_q;
    logic [CNT_W-1:0]   squash_cnt_d;
    logic               is_hlt;

    assign is_hlt = (instr_IM[INSTR_W-1 -: 4] == HLT_OP);

    // Saturate at all-ones so a long-running monitor never wraps back to a small value.
    assign squash_cnt_d = (&squash_cnt_q) ? squash_cnt_q
                                          : squash_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
            squash_cnt_q <= '0;
        end else if (!stall_IM_ID) begin
            if (flow_change_ID_EX) begin
                // Redirect wins in either state: the captured slot is wrong-path.
                state_q      <= RUN;
                instr_q      <= NOP_INSTR;
                valid_q      <= 1'b0;
                squash_cnt_q <= squash_cnt_d;
            end else begin
                case (state_q)
                    RUN: begin
                        instr_q <= instr_IM;
                        valid_q <= 1'b1;
                        if (is_hlt) begin
                            state_q <= HALT;
                        end
                    end
                    HALT: begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                    default: begin
                        state_q <= RUN;
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign instr_IM_ID = instr_q;
    assign valid_IM_ID = valid_q;
    assign halt_fetch  = (state_q == HALT);
    assign squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_instr_fetch_id.sv
// Self-checking bench for instr_fetch_id: directed plan plus random traffic,
// compared against a cycle-level behavioural model of the fetch/decode slot.
module tb_instr_fetch_id;

    localparam logic [15:0] NOP = 16'h0000;
    localparam int          CNT_MAX = 65535;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr_IM;
    logic        stall_IM_ID;
    logic        flow_change_ID_EX;
    logic [15:0] instr_IM_ID;
    logic        valid_IM_ID;
    logic        halt_fetch;
    logic [15:0] squash_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: what decode should see, whether fetch is frozen, squash total.
    logic [15:0] m_instr;
    logic        m_valid;
    logic        m_halted;
    int          m_squashes;

    instr_fetch_id dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_IM         (instr_IM),
        .stall_IM_ID      (stall_IM_ID),
        .flow_change_ID_EX(flow_change_ID_EX),
        .instr_IM_ID      (instr_IM_ID),
        .valid_IM_ID      (valid_IM_ID),
        .halt_fetch       (halt_fetch),
        .squash_cnt       (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instr"}, {16'h0, instr_IM_ID}, {16'h0, m_instr});
        check({tag, ".valid"}, {31'h0, valid_IM_ID}, {31'h0, m_valid});
        check({tag, ".halt"},  {31'h0, halt_fetch},  {31'h0, m_halted});
        check({tag, ".cnt"},   {16'h0, squash_cnt},  (m_squashes > CNT_MAX) ? CNT_MAX : m_squashes);
    endtask

    task automatic model_reset();
        m_instr    = NOP;
        m_valid    = 1'b0;
        m_halted   = 1'b0;
        m_squashes = 0;
    endtask

    // One clock of the model, from the rules for a stage register with HLT freeze.
    task automatic model_edge(input logic [15:0] ins, input logic st, input logic fl);
        if (st) return;
        if (fl) begin
            m_instr    = NOP;
            m_valid    = 1'b0;
            m_halted   = 1'b0;
            m_squashes = m_squashes + 1;
        end else if (m_halted) begin
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            m_instr = ins;
            m_valid = 1'b1;
            if (ins[15:12] == 4'hF) m_halted = 1'b1;
        end
    endtask

    task automatic step(input logic [15:0] ins, input logic st, input logic fl, input string tag);
        instr_IM          = ins;
        stall_IM_ID       = st;
        flow_change_ID_EX = fl;
        @(posedge clk);
        model_edge(ins, st, fl);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n             = 1'b0;
        instr_IM          = 16'h0;
        stall_IM_ID       = 1'b0;
        flow_change_ID_EX = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain fetch stream.
        step(16'h1234, 1'b0, 1'b0, "fetch0");
        step(16'h2345, 1'b0, 1'b0, "fetch1");
        step(16'h3456, 1'b0, 1'b0, "fetch2");

        // Stall holds the slot, release captures the waiting instruction.
        step(16'hA111, 1'b1, 1'b0, "stall0");
        step(16'hA111, 1'b1, 1'b0, "stall1");
        step(16'hA111, 1'b0, 1'b0, "release");

        // Redirect squashes; a redirect under stall is ignored.
        step(16'h5555, 1'b0, 1'b1, "squash");
        step(16'h6000, 1'b0, 1'b0, "refetch");
        step(16'h5555, 1'b1, 1'b1, "squash_stalled");

        // HLT is captured, then fetch stays frozen.
        step(16'hF000, 1'b0, 1'b0, "hlt");
        for (int i = 0; i < 5; i++) begin
            step(16'($urandom), 1'b0, 1'b0, "halted");
        end
        step(16'h1111, 1'b1, 1'b0, "halted_stall");

        // Redirect out of HALT, then normal capture resumes.
        step(16'h2222, 1'b0, 1'b1, "unhalt");
        step(16'h7777, 1'b0, 1'b0, "post_unhalt");

        // A squashed HLT must not freeze fetch.
        step(16'hF123, 1'b0, 1'b1, "hlt_squashed");
        step(16'h4321, 1'b0, 1'b0, "after_hlt_squash");

        // Random traffic with occasional HLTs, stalls and redirects.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ins[15:12] = 4'hF;
            step(ins, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0), "rand");
        end

        // Mid-cycle asynchronous reset clears everything before the next edge.
        step(16'hF0F0, 1'b0, 1'b0, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0ABC, 1'b0, 1'b0, "after_reset");

        // Drive the squash counter to saturation, then past it.
        while (m_squashes < CNT_MAX) begin
            instr_IM          = 16'($urandom);
            stall_IM_ID       = 1'b0;
            flow_change_ID_EX = 1'b1;
            @(posedge clk);
            model_edge(instr_IM, 1'b0, 1'b1);
        end
        #1;
        check_all("cnt_at_max");
        step(16'h5555, 1'b0, 1'b1, "cnt_saturated");
        step(16'h5555, 1'b0, 1'b1, "cnt_saturated2");
        step(16'h1357, 1'b0, 1'b0, "fetch_after_sat");

        // Reset mid-cycle while stalled also clears outputs.
        stall_IM_ID = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset_stalled");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
